stack_io_bridge: RTL and testbench

//  Memory-side stage directly downstream of the 8-bit core bus (AB[8:0], DO, WE, DI).

---
 rtl/stack_io_bridge.sv | 169 ++++++++++++++++
 tb/tb_stack_io_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_io_bridge.sv
// Page-1 stack RAM + byte I/O window behind the 8-bit core bus; page 0 passes through to program ROM.
// Latency: reads combinational in the same phase; all state updates on the next r_clk rise.
// Backpressure: TX FIFO stalls on tx_ready (overflow is flagged, not stalled); RX holds one byte via rx_ready.

module fifo_sync #(
    parameter int W  = 8,
    parameter int AW = 2
) (
    input  logic          r_clk,
    input  logic          reset,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Caller never writes a full FIFO without a same-edge read, nor reads an empty one.
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
            if (rd_rdy) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_vld, rd_rdy})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge r_clk) begin
        if (wr_vld) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
endmodule

module stack_io_bridge #(
    parameter logic [7:0] IO_BASE  = 8'hF0,
    parameter int         TX_DEPTH = 4,
    parameter int         TX_AW    = 2
) (
    input  logic       r_clk,
    input  logic       reset,
    input  logic [8:0] AB,
    input  logic [7:0] DO,
    input  logic       WE,
    output logic [7:0] DI,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);
    typedef struct packed {
        logic       tx_full;
        logic       tx_empty;
        logic       ovf;
        logic       rx_full;
        logic       rsvd;
        logic [2:0] count;
    } status_t;

    logic [7:0]   ram [256];
    logic         io_sel, ram_sel;
    logic [3:0]   offset;
    logic         push, stat_wr, rx_pop, drain, fifo_wr;
    logic         tx_full, tx_empty, ovf, rx_full;
    logic [7:0]   rx_byte, tx_head, io_rd_dat;
    logic [TX_AW:0] tx_count;
    logic [31:0]  cnt_ext;
    status_t      status;

    assign io_sel   = AB[8] && (AB[7:4] == IO_BASE[7:4]);
    assign ram_sel  = AB[8] && !io_sel;
    assign offset   = AB[3:0];
    assign push     = WE && io_sel && (offset == 4'h0);
    assign stat_wr  = WE && io_sel && (offset == 4'h1);
    assign rx_pop   = !WE && io_sel && (offset == 4'h2);
    assign drain    = tx_valid && tx_ready;
    // A push into a full FIFO only lands if the head leaves on the same edge.
    assign fifo_wr  = push && (!tx_full || drain);

    fifo_sync #(.W(8), .AW(TX_AW)) u_tx_fifo (
        .r_clk  (r_clk),
        .reset  (reset),
        .wr_vld (fifo_wr),
        .wr_dat (DO),
        .rd_rdy (drain),
        .rd_dat (tx_head),
        .count  (tx_count),
        .empty  (tx_empty),
        .full   (tx_full)
    );

    assign tx_valid = !tx_empty;
    assign tx_data  = tx_valid ? tx_head : 8'h00;
    assign rx_ready = !rx_full;
    assign rom_addr = AB[7:0];

    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (stat_wr) begin
            ovf <= 1'b0;
        end else if (push && tx_full && !drain) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            rx_full <= 1'b0;
            rx_byte <= 8'h00;
        end else if (rx_valid && rx_ready) begin
            rx_full <= 1'b1;
            rx_byte <= rx_data;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end
    end

    // Stack contents deliberately survive reset.
    always_ff @(posedge r_clk) begin
        if (WE && ram_sel) ram[AB[7:0]] <= DO;
    end

    assign cnt_ext = 32'(tx_count);

    always_comb begin
        status          = '0;
        status.tx_full  = tx_full;
        status.tx_empty = tx_empty;
        status.ovf      = ovf;
        status.rx_full  = rx_full;
        status.count    = (cnt_ext > 32'd7) ? 3'd7 : cnt_ext[2:0];
    end

    always_comb begin
        io_rd_dat = 8'h00;
        case (offset)
            4'h1:    io_rd_dat = status;
            4'h2:    io_rd_dat = rx_byte;
            default: io_rd_dat = 8'h00;
        endcase
    end

    always_comb begin
        DI = rom_data;
        if (ram_sel)     DI = ram[AB[7:0]];
        else if (io_sel) DI = io_rd_dat;
    end
endmodule

// File: tb/tb_stack_io_bridge.sv
// Bench for stack_io_bridge: directed scenarios then random bus traffic against a queue-based model.
module tb_stack_io_bridge;
    logic       r_clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] AB;
    logic [7:0] DO, DI, rom_addr, rom_data, tx_data, rx_data;
    logic       WE, tx_valid, tx_ready, rx_valid, rx_ready;

    stack_io_bridge dut (
        .r_clk    (r_clk),
        .reset    (reset),
        .AB       (AB),
        .DO       (DO),
        .WE       (WE),
        .DI       (DI),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
    );

    always #5 r_clk = ~r_clk;

    localparam int DEPTH = 4;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  txq [$];
    bit          m_ovf    = 1'b0;
    bit          m_rxf    = 1'b0;
    logic [7:0]  m_rxb    = 8'h00;
    logic [7:0]  m_ram [256];
    bit          m_known [256];
    logic [7:0]  pat [4];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        int n;
        n = txq.size();
        return {n == DEPTH, n == 0, m_ovf, m_rxf, 1'b0, (n > 7) ? 3'd7 : 3'(n)};
    endfunction

    task automatic drive(input logic [8:0] ab, input logic we, input logic [7:0] d);
        AB = ab;
        WE = we;
        DO = d;
    endtask

    // Called just after a falling edge with inputs set; checks, clocks once, updates the model.
    task automatic step();
        bit         io, ramh, push, drain, was_full;
        logic [3:0] off;
        #1;
        io   = AB[8] && (AB[7:4] == 4'hF);
        ramh = AB[8] && !io;
        off  = AB[3:0];
        chk("tx_valid", tx_valid, txq.size() != 0);
        chk("tx_data", tx_data, (txq.size() != 0) ? txq[0] : 8'h00);
        chk("rx_ready", rx_ready, !m_rxf);
        if (!AB[8])                 chk("di_rom", DI, rom_data);
        else if (ramh) begin
            if (m_known[AB[7:0]])   chk("di_ram", DI, m_ram[AB[7:0]]);
        end
        else if (off == 4'h1)       chk("di_status", DI, m_status());
        else if (off == 4'h2)       chk("di_rx", DI, m_rxb);
        else                        chk("di_io_zero", DI, 8'h00);
        push     = WE && io && (off == 4'h0);
        drain    = (txq.size() != 0) && tx_ready;
        was_full = (txq.size() == DEPTH);
        @(posedge r_clk);
        if (drain) void'(txq.pop_front());
        if (push && (!was_full || drain)) txq.push_back(DO);
        if (push && was_full && !drain) m_ovf = 1'b1;
        if (WE && io && off == 4'h1) m_ovf = 1'b0;
        if (rx_valid && !m_rxf) begin
            m_rxf = 1'b1;
            m_rxb = rx_data;
        end else if (!WE && io && off == 4'h2) begin
            m_rxf = 1'b0;
        end
        if (WE && ramh) begin
            m_ram[AB[7:0]]   = DO;
            m_known[AB[7:0]] = 1'b1;
        end
        @(negedge r_clk);
    endtask

    initial begin
        drive(9'h000, 1'b0, 8'h00);
        rom_data = 8'h5A;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

        repeat (3) @(negedge r_clk);
        AB = 9'h1F1;
        #1;
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_status", DI, 8'h40);
        @(negedge r_clk);
        reset = 1'b0;

        drive(9'h110, 1'b1, 8'hA5); step();
        drive(9'h110, 1'b0, 8'h00);
        #1 chk("ram_readback", DI, 8'hA5);
        step();
        rom_data = 8'hC3;
        drive(9'h010, 1'b0, 8'h00);
        #1 chk("rom_passthru", DI, 8'hC3);
        chk("rom_addr", rom_addr, 8'h10);
        step();

        for (int i = 0; i < 4; i++) begin
            drive(9'h1F0, 1'b1, pat[i]); step();
        end
        drive(9'h1F1, 1'b0, 8'h00);
        #1 chk("full_status", DI, 8'h84);
        step();
        drive(9'h1F0, 1'b1, 8'h55); step();
        drive(9'h1F1, 1'b0, 8'h00);
        #1 chk("ovf_status", DI, 8'hA4);
        step();
        tx_ready = 1'b1;
        drive(9'h000, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            #1 chk("drain_order", tx_data, pat[i]);
            step();
        end
        tx_ready = 1'b0;
        drive(9'h1F1, 1'b1, 8'hFF); step();
        drive(9'h1F1, 1'b0, 8'h00);
        #1 chk("ovf_cleared", DI, 8'h40);
        step();

        for (int i = 0; i < 4; i++) begin
            drive(9'h1F0, 1'b1, pat[i]); step();
        end
        tx_ready = 1'b1;
        drive(9'h1F0, 1'b1, 8'h66);
        #1 chk("full_push_head", tx_data, 8'h11);
        step();
        tx_ready = 1'b0;
        drive(9'h1F1, 1'b0, 8'h00);
        #1 chk("full_push_count", DI, 8'h84);
        chk("full_push_next", tx_data, 8'h22);
        step();
        tx_ready = 1'b1;
        drive(9'h000, 1'b0, 8'h00);
        repeat (4) step();
        #1 chk("full_push_emptied", tx_valid, 1'b0);
        tx_ready = 1'b0;

        rx_data  = 8'h3C;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1 chk("rx_ready_low", rx_ready, 1'b0);
        drive(9'h1F1, 1'b0, 8'h00);
        #1 chk("rx_status_bit4", DI[4], 1'b1);
        step();
        drive(9'h1F2, 1'b0, 8'h00);
        #1 chk("rx_byte", DI, 8'h3C);
        step();
        #1 chk("rx_ready_back", rx_ready, 1'b1);

        drive(9'h1F0, 1'b1, 8'hAA); step();
        drive(9'h1F0, 1'b1, 8'hBB); step();
        drive(9'h1F0, 1'b1, 8'hCC); step();
        drive(9'h1F1, 1'b0, 8'h00);
        #2 reset = 1'b1;
        #1;
        chk("midrst_tx_valid", tx_valid, 1'b0);
        chk("midrst_rx_ready", rx_ready, 1'b1);
        chk("midrst_status", DI, 8'h40);
        txq.delete();
        m_ovf = 1'b0;
        m_rxf = 1'b0;
        m_rxb = 8'h00;
        @(negedge r_clk);
        reset = 1'b0;
        drive(9'h110, 1'b0, 8'h00);
        #1 chk("midrst_ram_kept", DI, 8'hA5);
        step();

        repeat (400) begin
            case ($urandom_range(0, 4))
                0:       AB = {1'b0, 8'($urandom)};
                1:       AB = {1'b1, 4'($urandom_range(0, 14)), 4'($urandom)};
                2, 3:    AB = {1'b1, 4'hF, 4'($urandom_range(0, 3))};
                default: AB = {1'b1, 4'hF, 4'($urandom_range(4, 15))};
            endcase
            WE       = ($urandom_range(0, 4) < 2);
            DO       = 8'($urandom);
            rom_data = 8'($urandom);
            tx_ready = ($urandom_range(0, 9) < 3);
            rx_valid = $urandom_range(0, 1) == 1;
            rx_data  = 8'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
